// File: rtl/dsp_add32.sv
// ---------------------------------------------------------------------------
// dsp_add32
//   32-bit unsigned adder with carry-in/carry-out, styled after the iCE40
//   SB_MAC16 32-bit add mode. The sum is built from two 16-bit halves joined
//   by an internal carry, so it matches a flat 33-bit add bit for bit.
//   There is an optional input register stage and an optional output register
//   stage. Latency is IN_REG + OUT_REG cycles.
//
// Parameters
//   IN_REG   1 = register AB/CD/carryin (and sub) on clk, 0 = pass through
//   OUT_REG  1 = register O/carryout on clk,               0 = combinational
//
// Ports
//   clk       in   1   single clock, rising edge
//   rst       in   1   asynchronous, active-high reset (clears every register)
//   ce        in   1   clock enable shared by all register stages
//   AB        in   32  operand A
//   CD        in   32  operand B
//   carryin   in   1   carry into bit 0
//   sub       in   1   (DSP_ADD32_SUB_EN only) 1 = AB + ~CD + carryin
//   O         out  32  sum[31:0]
//   carryout  out  1   carry out of bit 31
//
// Configuration macro
//   DSP_ADD32_SUB_EN  when defined, adds the `sub` input. For AB-CD drive
//                     carryin=1; carryout=1 then means "no borrow".
// ---------------------------------------------------------------------------
module dsp_add32 #(
  parameter bit IN_REG  = 1'b1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] AB,
  input  logic [31:0] CD,
  input  logic        carryin,
`ifdef DSP_ADD32_SUB_EN
  input  logic        sub,
`endif
  output logic [31:0] O,
  output logic        carryout
);

  // 16-bit slice add; bit 16 of the result is the carry out of the slice.
  function automatic logic [16:0] add16(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic        c);
    add16 = {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  logic        sub_in_s;
  logic [31:0] ab_r;
  logic [31:0] cd_r;
  logic        cin_r;
  logic        sub_r;
  logic [31:0] ab_s;
  logic [31:0] cd_s;
  logic        cin_s;
  logic        sub_s;
  logic [31:0] cd_eff_s;
  logic [16:0] lo_s;
  logic [16:0] hi_s;
  logic [31:0] sum_s;
  logic        cout_s;
  logic [31:0] o_r;
  logic        co_r;

`ifdef DSP_ADD32_SUB_EN
  assign sub_in_s = sub;
`else
  // Add-only build: the subtract control is tied off.
  assign sub_in_s = 1'b0;
`endif

  // Input stage: captures the operand set on each enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_r  <= 32'd0;
      cd_r  <= 32'd0;
      cin_r <= 1'b0;
      sub_r <= 1'b0;
    end else if (ce) begin
      ab_r  <= AB;
      cd_r  <= CD;
      cin_r <= carryin;
      sub_r <= sub_in_s;
    end
  end

  // Selects registered or direct operands depending on IN_REG.
  always_comb begin
    ab_s  = AB;
    cd_s  = CD;
    cin_s = carryin;
    sub_s = sub_in_s;
    if (IN_REG) begin
      ab_s  = ab_r;
      cd_s  = cd_r;
      cin_s = cin_r;
      sub_s = sub_r;
    end else begin
      ab_s  = AB;
      cd_s  = CD;
      cin_s = carryin;
      sub_s = sub_in_s;
    end
  end

  // Two chained 16-bit halves; the low-half carry feeds the high half.
  always_comb begin
    cd_eff_s = cd_s;
    if (sub_s) begin
      cd_eff_s = ~cd_s;
    end else begin
      cd_eff_s = cd_s;
    end
    lo_s   = add16(ab_s[15:0],  cd_eff_s[15:0],  cin_s);
    hi_s   = add16(ab_s[31:16], cd_eff_s[31:16], lo_s[16]);
    sum_s  = {hi_s[15:0], lo_s[15:0]};
    cout_s = hi_s[16];
  end

  // Output stage: holds the last enabled result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_r  <= 32'd0;
      co_r <= 1'b0;
    end else if (ce) begin
      o_r  <= sum_s;
      co_r <= cout_s;
    end
  end

  // Selects registered or combinational result depending on OUT_REG.
  always_comb begin
    O        = sum_s;
    carryout = cout_s;
    if (OUT_REG) begin
      O        = o_r;
      carryout = co_r;
    end else begin
      O        = sum_s;
      carryout = cout_s;
    end
  end

endmodule

// File: tb/tb_dsp_add32.sv
module tb_dsp_add32;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] AB;
  logic [31:0] CD;
  logic        carryin;
  logic        sub;
  logic [31:0] O;
  logic        carryout;
  logic [31:0] o0;
  logic        co0;

  int n_cmp = 0;
  int n_bad = 0;

  // Results accepted by the default-parameter DUT, newest first.
  logic [32:0] hist[$];

  dsp_add32 dut (
    .clk(clk), .rst(rst), .ce(ce), .AB(AB), .CD(CD), .carryin(carryin),
`ifdef DSP_ADD32_SUB_EN
    .sub(sub),
`endif
    .O(O), .carryout(carryout)
  );

  dsp_add32 #(.IN_REG(1'b0), .OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .AB(AB), .CD(CD), .carryin(carryin),
`ifdef DSP_ADD32_SUB_EN
    .sub(sub),
`endif
    .O(o0), .carryout(co0)
  );

  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
    logic [31:0] bb;
    bb = s ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {32'd0, c};
  endfunction

  function automatic logic cur_sub();
`ifdef DSP_ADD32_SUB_EN
    return sub;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got co=%0b O=%h, expected co=%0b O=%h at %0t",
               name, got[32], got[31:0], exp[32], exp[31:0], $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: every enabled edge accepts one flat sum; output is the one LAT back.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
    end else if (ce) begin
      hist.push_front(ref_sum(AB, CD, carryin, cur_sub()));
      if (hist.size() > 4) void'(hist.pop_back());
    end
  end

  // Compare process: pipelined DUT against model, combinational DUT against flat sum.
  always @(negedge clk) begin
    logic [32:0] exp_v;
    exp_v = (hist.size() >= LAT) ? hist[LAT-1] : 33'd0;
    chk("pipe", {carryout, O}, exp_v);
    chk("comb", {co0, o0}, ref_sum(AB, CD, carryin, cur_sub()));
  end

  task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic c);
    AB = a;
    CD = b;
    carryin = c;
  endtask

  // Drive one vector and pin the literal result exactly LAT cycles later.
  task automatic pin_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [32:0] exp);
    @(posedge clk); #1;
    set_in(a, b, c);
    repeat (LAT) @(posedge clk);
    #1;
    chk(name, {carryout, O}, exp);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; sub = 1'b0;
    set_in(32'd0, 32'd0, 1'b0);
    #12;
    chk("reset", {carryout, O}, 33'd0);
    @(posedge clk); #1;
    rst = 1'b0; ce = 1'b1;

    pin_vec("spec1",  32'h67503B12, 32'hCD84DA1F, 1'b0, {1'b1, 32'h34D51531});
    pin_vec("spec2",  32'h7F7DF7D8, 32'hFFFFFFFF, 1'b0, {1'b1, 32'h7F7DF7D7});
    pin_vec("spec3",  32'h55555556, 32'hFFFFFFFF, 1'b0, {1'b1, 32'h55555555});
    pin_vec("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, {1'b1, 32'h00000000});
    pin_vec("zero",   32'h00000000, 32'h00000000, 1'b0, {1'b0, 32'h00000000});
    pin_vec("half",   32'h0000FFFF, 32'h00000001, 1'b0, {1'b0, 32'h00010000});
    pin_vec("hicarry",32'hFFFF0000, 32'h00010000, 1'b0, {1'b1, 32'h00000000});

    // Back-to-back streaming, one new operand set per cycle.
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      set_in($urandom, $urandom, 1'($urandom_range(1, 0)));
    end

    // Fill the pipe with a known value, then drop ce for 3 cycles.
    @(posedge clk); #1;
    set_in(32'h12345678, 32'h11111111, 1'b0);
    repeat (LAT) @(posedge clk);
    #1;
    ce = 1'b0;
    set_in(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold", {carryout, O}, {1'b0, 32'h23456789});
    end
    ce = 1'b1;

    // Stream, then reset asynchronously between clock edges.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_in($urandom, $urandom, 1'($urandom_range(1, 0)));
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst", {carryout, O}, 33'd0);
    @(negedge clk); #2;
    rst = 1'b0;
    set_in(32'h0000000A, 32'h00000014, 1'b1);
    @(posedge clk); #1;
    chk("refill", {carryout, O}, 33'd0);
    @(posedge clk); #1;
    chk("post_rst", {carryout, O}, {1'b0, 32'h0000001F});

`ifdef DSP_ADD32_SUB_EN
    @(posedge clk); #1;
    sub = 1'b1;
    set_in(32'h00000005, 32'h00000007, 1'b1);
    repeat (LAT) @(posedge clk);
    #1;
    chk("sub", {carryout, O}, {1'b0, 32'hFFFFFFFE});
    pin_vec("sub_nb", 32'h00000009, 32'h00000004, 1'b1, {1'b1, 32'h00000005});
    sub = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
